// File: rtl/ncpu32k_dcache_tdpram.sv
// True dual-port byte-lane RAM for the D-cache data/tag arrays.
// Each byte lane is its own narrow dual-port RAM; A/B read-during-write modes are per-port parameters.
module ncpu32k_dcache_tdpram_lane #(
  parameter int AW            = 8,
  parameter int WRITE_FIRST_A = 1,
  parameter int WRITE_FIRST_B = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    din_a,
  output logic [7:0]    dout_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    din_b,
  output logic [7:0]    dout_b
);
  logic [7:0] mem [2**AW];

  // Port B is written first so port A's write overrides it on a same-byte collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (en_b && we_b) mem[addr_b] <= din_b;
      if (en_a && we_a) mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (en_a) dout_a <= ((WRITE_FIRST_A != 0) && we_a) ? din_a : mem[addr_a];
      if (en_b) dout_b <= ((WRITE_FIRST_B != 0) && we_b) ? din_b : mem[addr_b];
    end
  end
endmodule

module ncpu32k_dcache_tdpram #(
  parameter int AW            = 8,
  parameter int DW            = 32,
  parameter int WRITE_FIRST_A = 1,
  parameter int WRITE_FIRST_B = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   addr_a,
  input  logic [DW/8-1:0] we_a,
  input  logic [DW-1:0]   din_a,
  output logic [DW-1:0]   dout_a,
  input  logic            en_a,
  input  logic [AW-1:0]   addr_b,
  input  logic [DW/8-1:0] we_b,
  input  logic [DW-1:0]   din_b,
  output logic [DW-1:0]   dout_b,
  input  logic            en_b
);
  localparam int NUM_LANES = DW / 8;

  logic [NUM_LANES-1:0][7:0] din_a_l, din_b_l, dout_a_l, dout_b_l;

  assign din_a_l = din_a;
  assign din_b_l = din_b;
  assign dout_a  = dout_a_l;
  assign dout_b  = dout_b_l;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ncpu32k_dcache_tdpram_lane #(
      .AW(AW), .WRITE_FIRST_A(WRITE_FIRST_A), .WRITE_FIRST_B(WRITE_FIRST_B)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_a  (en_a),
      .we_a  (we_a[g]),
      .addr_a(addr_a),
      .din_a (din_a_l[g]),
      .dout_a(dout_a_l[g]),
      .en_b  (en_b),
      .we_b  (we_b[g]),
      .addr_b(addr_b),
      .din_b (din_b_l[g]),
      .dout_b(dout_b_l[g])
    );
  end
endmodule

// File: tb/tb_ncpu32k_dcache_tdpram.sv
// Bench for ncpu32k_dcache_tdpram: byte-level memory model checked every cycle plus literal spot checks.
module tb_ncpu32k_dcache_tdpram;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  addr_a = '0, addr_b = '0;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [31:0] dout_a, dout_b;

  int checks = 0;
  int fails  = 0;

  ncpu32k_dcache_tdpram dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .we_a(we_a), .din_a(din_a), .dout_a(dout_a), .en_a(en_a),
    .addr_b(addr_b), .we_b(we_b), .din_b(din_b), .dout_b(dout_b), .en_b(en_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] msk);
    checks++;
    if ((act & msk) !== (exp & msk)) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (mask %08h) at %0t", name, act, exp, msk, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Model: memory bytes plus a per-byte "written since power-up" flag.
  logic [31:0] mm [256];
  logic [3:0]  mk [256];
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [3:0]  em_a = '0, em_b = '0;

  initial for (int i = 0; i < 256; i++) begin mm[i] = '0; mk[i] = '0; end

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] pre_a, pre_b;
    logic [3:0]  pk_a, pk_b;
    if (!rst_n) begin
      exp_a = '0; exp_b = '0; em_a = '1; em_b = '1;
    end else begin
      pre_a = mm[addr_a]; pk_a = mk[addr_a];
      pre_b = mm[addr_b]; pk_b = mk[addr_b];
      if (en_a)
        for (int i = 0; i < 4; i++) begin
          exp_a[8*i +: 8] = we_a[i] ? din_a[8*i +: 8] : pre_a[8*i +: 8];
          em_a[i]         = we_a[i] | pk_a[i];
        end
      if (en_b) begin exp_b = pre_b; em_b = pk_b; end
      if (en_b)
        for (int i = 0; i < 4; i++)
          if (we_b[i]) begin mm[addr_b][8*i +: 8] = din_b[8*i +: 8]; mk[addr_b][i] = 1'b1; end
      if (en_a)
        for (int i = 0; i < 4; i++)
          if (we_a[i]) begin mm[addr_a][8*i +: 8] = din_a[8*i +: 8]; mk[addr_a][i] = 1'b1; end
    end
  end

  always @(negedge clk) begin
    if (em_a != 0) chk("model_dout_a", dout_a, exp_a, bmask(em_a));
    if (em_b != 0) chk("model_dout_b", dout_b, exp_b, bmask(em_b));
  end

  task automatic cyc(input logic ea, input logic [7:0] aa, input logic [3:0] wa, input logic [31:0] da,
                     input logic eb, input logic [7:0] ab, input logic [3:0] wb, input logic [31:0] db);
    en_a = ea; addr_a = aa; we_a = wa; din_a = da;
    en_b = eb; addr_b = ab; we_b = wb; din_b = db;
    @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'd5,  4'hF, 32'h5A5A1234, 0, 8'd0, 4'h0, 32'h0);
    cyc(1, 8'd7,  4'hF, 32'h11223344, 1, 8'd9, 4'hF, 32'h01020304);
    cyc(1, 8'd2,  4'hF, 32'h00000000, 1, 8'd5, 4'h0, 32'h0);
    chk("b_read_5", dout_b, 32'h5A5A1234, '1);

    // Reset asserted mid-cycle must clear outputs immediately and block writes.
    cyc(1, 8'd5, 4'h0, 32'h0, 1, 8'd7, 4'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_a", dout_a, 32'h0, '1);
    chk("async_rst_b", dout_b, 32'h0, '1);
    @(negedge clk);
    cyc(1, 8'd5, 4'hF, 32'hFFFFFFFF, 1, 8'd5, 4'hF, 32'hEEEEEEEE);
    chk("rst_hold_a", dout_a, 32'h0, '1);
    chk("rst_hold_b", dout_b, 32'h0, '1);
    rst_n = 1'b1;
    cyc(1, 8'd5, 4'h0, 32'h0, 1, 8'd5, 4'h0, 32'h0);
    chk("post_rst_a5", dout_a, 32'h5A5A1234, '1);
    chk("post_rst_b5", dout_b, 32'h5A5A1234, '1);

    // Port A write-first, then visible on B.
    cyc(1, 8'd3, 4'hF, 32'hDEADBEEF, 0, 8'd0, 4'h0, 32'h0);
    chk("wf_a", dout_a, 32'hDEADBEEF, '1);
    cyc(0, 8'd0, 4'h0, 32'h0, 1, 8'd3, 4'h0, 32'h0);
    chk("wf_b_readback", dout_b, 32'hDEADBEEF, '1);

    // Byte mask merge.
    cyc(1, 8'd7, 4'b0101, 32'hAABBCCDD, 0, 8'd0, 4'h0, 32'h0);
    chk("mask_a", dout_a, 32'h11BB33DD, '1);
    cyc(0, 8'd0, 4'h0, 32'h0, 1, 8'd7, 4'h0, 32'h0);
    chk("mask_b_readback", dout_b, 32'h11BB33DD, '1);

    // Port B read-first.
    cyc(0, 8'd0, 4'h0, 32'h0, 1, 8'd9, 4'hF, 32'hCAFEF00D);
    chk("rf_b_old", dout_b, 32'h01020304, '1);
    cyc(0, 8'd0, 4'h0, 32'h0, 1, 8'd9, 4'h0, 32'h0);
    chk("rf_b_new", dout_b, 32'hCAFEF00D, '1);

    // Same-address collision.
    cyc(1, 8'd2, 4'b0001, 32'h000000AA, 1, 8'd2, 4'b0011, 32'h0000BBCC);
    chk("coll_a", dout_a, 32'h000000AA, '1);
    chk("coll_b", dout_b, 32'h00000000, '1);
    cyc(1, 8'd2, 4'h0, 32'h0, 1, 8'd2, 4'h0, 32'h0);
    chk("coll_mem_a", dout_a, 32'h0000BBAA, '1);
    chk("coll_mem_b", dout_b, 32'h0000BBAA, '1);

    // Enable low holds output and blocks writes.
    cyc(1, 8'd11, 4'hF, 32'h12345678, 0, 8'd0, 4'h0, 32'h0);
    cyc(1, 8'd10, 4'hF, 32'h00000055, 0, 8'd0, 4'h0, 32'h0);
    cyc(0, 8'd11, 4'hF, 32'h00000099, 0, 8'd11, 4'hF, 32'h00000077);
    chk("en_hold_a", dout_a, 32'h00000055, '1);
    cyc(1, 8'd11, 4'h0, 32'h0, 1, 8'd10, 4'h0, 32'h0);
    chk("en_nowrite_a", dout_a, 32'h12345678, '1);
    chk("en_read_b", dout_b, 32'h00000055, '1);

    // Mixed traffic over a small address window, checked by the model.
    for (int n = 0; n < 60; n++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
    cyc(0, 8'd0, 4'h0, 32'h0, 0, 8'd0, 4'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ncpu32k_dcache_tdpram.md
Name: ncpu32k_dcache_tdpram

Overview:
- True dual-port synchronous RAM backing the D-cache data/tag arrays, with per-byte write enables on both ports.
- Port A (core/lookup side) is write-first. Port B (refill/writeback side) is read-first.
- Both ports run on one clock. An asynchronous active-low reset clears only the read-data output registers; array contents are never reset.

Parameters:
- AW, 8, address width; depth = 2^AW words.
- DW, 32, data width in bits; must be a multiple of 8; byte lanes = DW/8.
- WRITE_FIRST_A, 1, port A read-during-write mode: 1 = write-first, 0 = read-first.
- WRITE_FIRST_B, 0, port B read-during-write mode: 1 = write-first, 0 = read-first.

Ports:
- clk  input  1  single clock, rising-edge active for both ports.
- rst_n  input  1  asynchronous active-low reset.
- addr_a  input  AW  port A word address.
- we_a  input  DW/8  port A byte write enables; bit i covers din_a[8i+7:8i].
- din_a  input  DW  port A write data.
- dout_a  output  DW  port A registered read data.
- en_a  input  1  port A enable.
- addr_b  input  AW  port B word address.
- we_b  input  DW/8  port B byte write enables.
- din_b  input  DW  port B write data.
- dout_b  output  DW  port B registered read data.
- en_b  input  1  port B enable.

Behaviour:
- Reset: rst_n low asynchronously forces dout_a = 0 and dout_b = 0.
  - While rst_n is low: no writes, no reads; array contents preserved.
  - Deassertion takes effect at the next rising clk.
- Array contents after power-up are undefined (X in simulation) until written.
- Port enable low: no read, no write; dout of that port holds its last value.
- Read latency is 1 cycle.
  - Enable high at edge N → dout valid after edge N, held until the next enabled edge.
  - Read and write of a port happen in the same enabled cycle.
- Byte write: for each i with we_x[i] = 1 under en_x, mem[addr_x] byte i <= din_x byte i. Other bytes are unchanged.
- Port A, write-first:
  - Written bytes of dout_a = din_a bytes.
  - Unwritten bytes of dout_a = pre-edge memory bytes.
  - we_a = 0 gives a plain read.
- Port B, read-first: dout_b = pre-edge mem[addr_b], whether or not bytes are written that cycle.
- WRITE_FIRST_x parameters select the mode per port with the rules above; defaults give A write-first, B read-first.
- Same-address collision, both enabled in the same cycle:
  - Both write the same byte: port A wins for that byte. Disjoint bytes from each port are both written.
  - Port A read-data: pre-edge memory merged with port A's own written bytes. Port B's concurrent write is not visible to dout_a that cycle.
  - Port B read-data: pre-edge memory only.
  - All writes are visible to both ports from the next cycle.
- Different addresses: ports are fully independent.
- No wrap or overflow cases; every address 0..2^AW-1 is valid.

Test Plan:
- Reset: hold rst_n = 0 with en_a = en_b = 1 and we = 0xF → dout_a = dout_b = 0, no writes. Release and read addr 5 → memory unchanged.
- Port A write-first: write 0xDEADBEEF at addr 3, we_a = 0xF → dout_a = 0xDEADBEEF the next cycle. Port B read of addr 3 one cycle later → 0xDEADBEEF.
- Byte mask: mem[7] = 0x11223344, then port A we_a = 0b0101 with din = 0xAABBCCDD → dout_a = 0x11BB33DD, and mem[7] reads 0x11BB33DD on port B.
- Port B read-first: mem[9] = 0x01020304, then port B writes 0xCAFEF00D → dout_b = 0x01020304. Port B read next cycle → 0xCAFEF00D.
- Collision: mem[2] = 0, A writes 0x000000AA (we = 0b0001) and B writes 0x0000BBCC (we = 0b0011) in the same cycle.
  - dout_a = 0x000000AA, dout_b = 0x00000000.
  - mem[2] = 0x0000BBAA on the next read.
- Enable hold: read 0x55 onto dout_a, then en_a = 0 with a new address and we → dout_a stays 0x55 and memory is not written.
